// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one data-memory port between instruction fetch and EXU loads/stores
// Registered request/ready handshake, EX-priority arbitration with fetch anti-starvation, sticky bus timeout.
module mem_port_arbiter #(
   parameter int TIMEOUT = 15
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic [31:0] if_rdata,
   output logic        if_ack,
   input  logic        ex_rd,
   input  logic        ex_wr,
   input  logic [31:0] ex_addr,
   input  logic [31:0] ex_wdata,
   input  logic [3:0]  ex_rmask,
   input  logic [3:0]  ex_wmask,
   output logic [31:0] ex_rdata,
   output logic        ex_ack,
   output logic        stall,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_rmask,
   output logic [3:0]  mem_wmask,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ready,
   output logic [1:0]  err
);
   typedef enum logic [1:0] {IDLE, DATA, FETCH, ERR} state_t;
   state_t state, state_nxt;
   logic [7:0] cnt;
   logic last_data, ex_v, if_v, grant_ex, grant_if, busy, done, tout;
   assign stall = (ex_rd | ex_wr) & ~ex_ack;
   // a requester being acked this cycle is not re-arbitrated until the next cycle
   always_comb begin
      ex_v = (ex_rd | ex_wr) & ~ex_ack;
      if_v = if_req & ~if_ack;
      busy = (state == DATA) || (state == FETCH);
      grant_ex = (state == IDLE) && ex_v && !(if_v && last_data);
      grant_if = (state == IDLE) && if_v && !grant_ex;
      done = busy && mem_ready;
      tout = busy && !mem_ready && (cnt + 8'd1 == 8'(TIMEOUT));
      state_nxt = grant_ex ? DATA : grant_if ? FETCH : done ? IDLE : tout ? ERR : state;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_rmask <= '0;
         mem_wmask <= '0;
         if_rdata  <= '0;
         ex_rdata  <= '0;
         if_ack    <= 1'b0;
         ex_ack    <= 1'b0;
         err       <= 2'b00;
         cnt       <= '0;
         last_data <= 1'b0;
      end else begin
         mem_req <= (state_nxt == DATA) || (state_nxt == FETCH);
         if_ack  <= done && (state == FETCH);
         ex_ack  <= done && (state == DATA);
         cnt     <= (grant_ex || grant_if) ? 8'd0 : (busy && !mem_ready) ? cnt + 8'd1 : cnt;
         // dual strobe resolves to a write
         if (grant_ex) begin
            mem_we    <= ex_wr;
            mem_addr  <= ex_addr;
            mem_wdata <= ex_wdata;
            mem_rmask <= ex_wr ? 4'b0000 : ex_rmask;
            mem_wmask <= ex_wr ? ex_wmask : 4'b0000;
         end else if (grant_if) begin
            mem_we    <= 1'b0;
            mem_addr  <= if_addr;
            mem_wdata <= '0;
            mem_rmask <= 4'b1111;
            mem_wmask <= 4'b0000;
         end
         if (done && (state == FETCH)) if_rdata <= mem_rdata;
         if (done && (state == DATA) && !mem_we) ex_rdata <= mem_rdata;
         if (done) last_data <= (state == DATA);
         if (tout) err <= 2'b11;
      end
   end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: transaction-level model plus directed scenarios for mem_port_arbiter
module tb_mem_port_arbiter;
   localparam int TO = 4;
   logic        clk = 0, rst = 1;
   logic        if_req = 0, ex_rd = 0, ex_wr = 0, mem_ready = 0;
   logic [31:0] if_addr = 0, ex_addr = 0, ex_wdata = 0, rd_base = 0;
   logic [3:0]  ex_rmask = 0, ex_wmask = 0;
   logic [31:0] if_rdata, ex_rdata, mem_addr, mem_wdata, mem_rdata;
   logic        if_ack, ex_ack, stall, mem_req, mem_we;
   logic [3:0]  mem_rmask, mem_wmask;
   logic [1:0]  err;
   int n_chk = 0, n_fail = 0;
   int lat = 0, wcnt = 0;
   bit ready_force = 0, ready_never = 0;

   mem_port_arbiter #(.TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
      .ex_rd(ex_rd), .ex_wr(ex_wr), .ex_addr(ex_addr), .ex_wdata(ex_wdata), .ex_rmask(ex_rmask),
      .ex_wmask(ex_wmask), .ex_rdata(ex_rdata), .ex_ack(ex_ack), .stall(stall), .mem_req(mem_req),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rmask(mem_rmask),
      .mem_wmask(mem_wmask), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .err(err)
   );

   always #5 clk = ~clk;
   assign mem_rdata = rd_base ^ mem_addr;

   // memory: ready after lat wait cycles of an open request
   initial forever begin
      @(posedge clk);
      #2;
      wcnt = mem_req ? wcnt + 1 : 0;
      mem_ready = ready_force | (!ready_never && mem_req && wcnt > lat);
   end

   // model: kind 0 none, 1 ex access, 2 fetch, 3 timed out
   int m_kind = 0, m_wait = 0;
   bit m_req = 0, m_ack_ex = 0, m_ack_if = 0, m_last_ex = 0, m_we = 0;
   logic [1:0]  m_err = 0;
   logic [31:0] m_addr = 0, m_wdata = 0, m_ex_rd = 0, m_if_rd = 0;
   logic [3:0]  m_rmask = 0, m_wmask = 0;

   task automatic model_step();
      bit pend_ex, pend_if;
      if (rst) begin
         m_kind = 0; m_wait = 0; m_req = 0; m_ack_ex = 0; m_ack_if = 0; m_last_ex = 0;
         m_err = 0; m_ex_rd = 0; m_if_rd = 0;
         return;
      end
      pend_ex = (ex_rd || ex_wr) && !m_ack_ex;
      pend_if = if_req && !m_ack_if;
      m_ack_ex = 0;
      m_ack_if = 0;
      if (m_kind == 1 || m_kind == 2) begin
         if (mem_ready) begin
            if (m_kind == 1) begin
               m_ack_ex = 1;
               if (!m_we) m_ex_rd = mem_rdata;
            end else begin
               m_ack_if = 1;
               m_if_rd = mem_rdata;
            end
            m_last_ex = (m_kind == 1);
            m_kind = 0;
         end else begin
            m_wait++;
            if (m_wait == TO) begin m_kind = 3; m_err = 2'b11; end
         end
      end else if (m_kind == 0) begin
         if (pend_ex && !(pend_if && m_last_ex)) begin
            m_kind = 1; m_wait = 0; m_we = ex_wr; m_addr = ex_addr; m_wdata = ex_wdata;
            m_rmask = ex_rmask; m_wmask = ex_wr ? ex_wmask : 4'b0000;
         end else if (pend_if) begin
            m_kind = 2; m_wait = 0; m_we = 0; m_addr = if_addr; m_rmask = 4'b1111; m_wmask = 0;
         end
      end
      m_req = (m_kind == 1 || m_kind == 2);
   endtask

   initial forever begin
      @(posedge clk or posedge rst);
      model_step();
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   initial forever begin
      @(negedge clk);
      chk("mem_req", {31'b0, mem_req}, {31'b0, m_req});
      chk("ex_ack", {31'b0, ex_ack}, {31'b0, m_ack_ex});
      chk("if_ack", {31'b0, if_ack}, {31'b0, m_ack_if});
      chk("err", {30'b0, err}, {30'b0, m_err});
      chk("stall", {31'b0, stall}, {31'b0, (ex_rd | ex_wr) & ~m_ack_ex});
      chk("ex_rdata", ex_rdata, m_ex_rd);
      chk("if_rdata", if_rdata, m_if_rd);
      if (m_req) begin
         chk("mem_addr", mem_addr, m_addr);
         chk("mem_we", {31'b0, mem_we}, {31'b0, m_we});
         chk("mem_wmask", {28'b0, mem_wmask}, {28'b0, m_wmask});
         if (m_we) chk("mem_wdata", mem_wdata, m_wdata);
         else      chk("mem_rmask", {28'b0, mem_rmask}, {28'b0, m_rmask});
      end
   end

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic wait_ack(input bit is_ex, input int exp_n, input string name);
      int n = 0;
      bit got = 0;
      while (!got && n < 40) begin
         step();
         n++;
         got = is_ex ? ex_ack : if_ack;
      end
      chk(name, n, exp_n);
   endtask

   initial begin
      int ord[4];
      int exp_ord[4] = '{1, 2, 1, 2};
      int k, n, acks;
      repeat (2) step();
      chk("reset_mem_req", {31'b0, mem_req}, 32'd0);
      chk("reset_err", {30'b0, err}, 32'd0);
      rst = 0;
      step();
      // single load, two wait cycles
      rd_base = 32'hDEADBFEF; lat = 2;
      ex_addr = 32'h100; ex_rmask = 4'b0110; ex_rd = 1;
      wait_ack(1, 4, "load_latency");
      ex_rd = 0;
      chk("load_rdata", ex_rdata, 32'hDEADBEEF);
      chk("load_we", {31'b0, mem_we}, 32'd0);
      chk("load_rmask", {28'b0, mem_rmask}, 32'h6);
      step();
      // store, memory ready at once
      lat = 0; ex_addr = 32'h20; ex_wdata = 32'h12345678; ex_wmask = 4'b0011; ex_wr = 1;
      wait_ack(1, 2, "store_latency");
      ex_wr = 0;
      chk("store_we", {31'b0, mem_we}, 32'd1);
      chk("store_wmask", {28'b0, mem_wmask}, 32'h3);
      chk("store_keeps_rdata", ex_rdata, 32'hDEADBEEF);
      step();
      // lone fetch so the last grant is a fetch
      rd_base = 32'h1111_0000; if_addr = 32'h40; if_req = 1;
      wait_ack(0, 2, "fetch_latency");
      if_req = 0;
      chk("fetch_rdata", if_rdata, 32'h1111_0040);
      step();
      // contention: both held high, grants must alternate
      lat = 1; ex_addr = 32'h300; ex_rd = 1; if_addr = 32'h400; if_req = 1;
      k = 0;
      for (int i = 0; i < 60 && k < 4; i++) begin
         step();
         if (ex_ack) ord[k++] = 1;
         else if (if_ack) ord[k++] = 2;
      end
      ex_rd = 0; if_req = 0;
      chk("contention_grants", k, 4);
      for (int i = 0; i < 4; i++) chk("contention_order", ord[i], exp_ord[i]);
      chk("contention_ex_rdata", ex_rdata, 32'h1111_0300);
      chk("contention_if_rdata", if_rdata, 32'h1111_0400);
      step();
      // dual strobe is one write with one ack
      lat = 0; ex_addr = 32'h50; ex_wmask = 4'b1111; ex_wdata = 32'hCAFE0001; ex_rd = 1; ex_wr = 1;
      wait_ack(1, 2, "dual_latency");
      chk("dual_we", {31'b0, mem_we}, 32'd1);
      ex_rd = 0; ex_wr = 0;
      acks = 0;
      repeat (4) begin step(); acks += int'(ex_ack); end
      chk("dual_extra_acks", acks, 0);
      // ready while no request is open must do nothing
      ready_force = 1;
      repeat (3) step();
      ready_force = 0;
      chk("idle_ready_ignored", {31'b0, mem_req}, 32'd0);
      step();
      // reset in the middle of a data access
      lat = 10; ex_addr = 32'h600; ex_rd = 1;
      repeat (2) @(negedge clk);
      #3 rst = 1;
      #1;
      chk("async_rst_mem_req", {31'b0, mem_req}, 32'd0);
      chk("async_rst_ex_ack", {31'b0, ex_ack}, 32'd0);
      step();
      ex_rd = 0;
      step();
      rst = 0;
      step();
      lat = 0; if_addr = 32'h700; if_req = 1;
      wait_ack(0, 2, "post_rst_fetch");
      if_req = 0;
      chk("post_rst_if_rdata", if_rdata, 32'h1111_0700);
      step();
      // bus timeout, memory never answers
      ready_never = 1; if_addr = 32'h80; if_req = 1;
      n = 0;
      while (err != 2'b11 && n < 40) begin step(); n++; end
      chk("timeout_latency", n, 5);
      repeat (4) step();
      ex_rd = 1;
      step();
      chk("err_stall", {31'b0, stall}, 32'd1);
      chk("err_mem_req", {31'b0, mem_req}, 32'd0);
      chk("err_sticky", {30'b0, err}, 32'h3);
      repeat (2) step();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
